// File: rtl/sonic_dma_cbuf_tx.sv
// SoNIC DMA TX ring: 128-bit words in, 40-bit LSB-first stream out.
// Single-clock circular RAM feeding a residue-register gearbox.
module sonic_dma_cbuf_tx #(
  parameter int DATA_IN_WIDTH  = 128,
  parameter int DATA_OUT_WIDTH = 40,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_IN_WIDTH-1:0]  wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      rd_en,
  output logic [DATA_OUT_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = DATA_IN_WIDTH + DATA_OUT_WIDTH;
  localparam int CW = $clog2(RW);

  localparam logic [CW-1:0] OWC  = CW'(DATA_OUT_WIDTH);
  localparam logic [CW-1:0] IWC  = CW'(DATA_IN_WIDTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [DATA_IN_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] residue;
  logic [RW-1:0] shifted;
  logic [RW-1:0] res_next;
  logic [CW-1:0] res_bits;
  logic [CW-1:0] nb;
  logic [CW-1:0] bits_next;
  logic          wr_fire;
  logic          pop;
  logic          load;

  assign wr_ready = (level != FULL);
  assign rd_valid = (res_bits >= OWC);
  assign rd_data  = residue[DATA_OUT_WIDTH-1:0];
  assign wr_fire  = wr_valid && wr_ready;
  assign pop      = rd_en && rd_valid;

  // Load decision uses registered level, so a fresh write waits a cycle.
  always_comb begin
    nb        = pop ? (res_bits - OWC) : res_bits;
    shifted   = pop ? (residue >> DATA_OUT_WIDTH) : residue;
    load      = (nb < OWC) && (level != '0);
    res_next  = shifted;
    bits_next = nb;
    if (load) begin
      res_next  = shifted
                | ({{DATA_OUT_WIDTH{1'b0}}, mem[rd_ptr]} << nb);
      bits_next = nb + IWC;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      residue  <= '0;
      res_bits <= '0;
    end else begin
      residue  <= res_next;
      res_bits <= bits_next;
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (load)    rd_ptr <= rd_ptr + AW'(1);
      if (wr_fire && !load)
        level <= level + (AW+1)'(1);
      else if (load && !wr_fire)
        level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_sonic_dma_cbuf_tx.sv
// Bench for sonic_dma_cbuf_tx: queue/bit-stream reference model,
// directed slices, full, reset and randomized wrap-around traffic.
module tb_sonic_dma_cbuf_tx;

  localparam int IW    = 128;
  localparam int OW    = 40;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IW-1:0]  wr_data = '0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic           rd_en = 1'b0;
  logic [OW-1:0]  rd_data;
  logic           rd_valid;
  logic [4:0]     level;

  int n_cmp = 0;
  int n_err = 0;

  logic [IW-1:0] ramq [$];
  bit            bq [$];
  logic [OW-1:0] got [$];

  sonic_dma_cbuf_tx #(
    .DATA_IN_WIDTH (IW),
    .DATA_OUT_WIDTH(OW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [IW-1:0] obs,
                     input logic [IW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] m_data();
    logic [OW-1:0] r = '0;
    for (int i = 0; i < OW && i < bq.size(); i++) r[i] = bq[i];
    return r;
  endfunction

  function automatic logic [IW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge: drive, check, advance model across one posedge.
  task automatic cyc(input logic wv, input logic [IW-1:0] wd,
                     input logic re);
    bit mpop, mload, mwr;
    int nb;
    logic [IW-1:0] w;
    wr_valid = wv;
    wr_data  = wd;
    rd_en    = re;
    chk("rd_valid", rd_valid, bq.size() >= OW);
    chk("rd_data", rd_data, m_data());
    chk("level", level, ramq.size());
    chk("wr_ready", wr_ready, ramq.size() < DEPTH);
    mpop  = re && bq.size() >= OW;
    if (mpop) got.push_back(rd_data);
    nb    = bq.size() - (mpop ? OW : 0);
    mload = nb < OW && ramq.size() > 0;
    mwr   = wv && ramq.size() < DEPTH;
    @(posedge clk);
    if (mpop) repeat (OW) void'(bq.pop_front());
    if (mload) begin
      w = ramq.pop_front();
      for (int i = 0; i < IW; i++) bq.push_back(w[i]);
    end
    if (mwr) ramq.push_back(wd);
    @(negedge clk);
  endtask

  task automatic reset_mid();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_data", rd_data, 0);
    ramq.delete();
    bq.delete();
    got.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    logic [IW-1:0]     w0;
    logic [IW-1:0]     sw [5];
    logic [5*IW-1:0]   ss;
    logic [IW-1:0]     fw [17];
    logic [17*IW-1:0]  fs;
    logic [IW-1:0]     tmp;
    logic [OW-1:0]     ex;
    int k, cycles, idx;
    bit wv, re, acc;

    repeat (2) @(negedge clk);
    chk("init_level", level, 0);
    chk("init_rd_valid", rd_valid, 0);
    chk("init_wr_ready", wr_ready, 1);
    chk("init_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // single word, continuous read
    w0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    cyc(1, w0, 1);
    chk("lat_level", level, 1);
    chk("lat_rd_valid", rd_valid, 0);
    cyc(0, '0, 1);
    chk("sw_valid", rd_valid, 1);
    chk("sw_out0", rd_data, 40'h9876543210);
    cyc(0, '0, 1);
    chk("sw_out1", rd_data, 40'hCDEFFEDCBA);
    cyc(0, '0, 1);
    chk("sw_out2", rd_data, 40'h23456789AB);
    cyc(0, '0, 1);
    chk("sw_tail_valid", rd_valid, 0);
    chk("sw_tail_data", rd_data, 40'h01);

    // mid-stream asynchronous reset
    for (int i = 0; i < 3; i++) cyc(1, rnd128(), 1);
    reset_mid();

    // boundary straddle over five words
    for (int i = 0; i < 5; i++) begin
      sw[i] = rnd128();
      ss[IW*i +: IW] = sw[i];
    end
    for (int i = 0; i < 5; i++) cyc(1, sw[i], 1);
    repeat (30) cyc(0, '0, 1);
    chk("str_count", got.size(), 16);
    if (got.size() >= 4) begin
      tmp = sw[1];
      w0  = sw[0];
      chk("str_out3", got[3], {tmp[31:0], w0[127:120]});
    end
    for (int j = 0; j < 16 && j < got.size(); j++)
      chk("str_stream", got[j], ss[OW*j +: OW]);
    chk("str_end_valid", rd_valid, 0);
    chk("str_end_data", rd_data, 0);
    reset_mid();

    // fill to full with no reads, then drain
    for (int i = 0; i < 17; i++) begin
      fw[i] = rnd128();
      fs[IW*i +: IW] = fw[i];
    end
    for (int i = 0; i < 17; i++) begin
      cyc(1, fw[i], 0);
      if (i == 1) begin
        chk("simul_level", level, 1);
        tmp = fw[0];
        chk("simul_data", rd_data, tmp[39:0]);
      end
    end
    chk("full_level", level, 16);
    chk("full_wr_ready", wr_ready, 0);
    cyc(1, rnd128(), 0);
    chk("full_ignored", level, 16);
    repeat (80) cyc(0, '0, 1);
    chk("full_count", got.size(), 54);
    for (int j = 0; j < 54 && j < got.size(); j++)
      chk("full_stream", got[j], fs[OW*j +: OW]);
    chk("full_level0", level, 0);
    reset_mid();

    // random wrap-around traffic with counter words
    k = 0;
    cycles = 0;
    while ((k < 100 || ramq.size() > 0 || bq.size() >= OW)
           && cycles < 5000) begin
      wv  = (k < 100) && ($urandom_range(0, 3) != 0);
      re  = ($urandom_range(0, 2) != 0);
      acc = wv && ramq.size() < DEPTH;
      cyc(wv, IW'(k), re);
      if (acc) k++;
      cycles++;
    end
    chk("wrap_budget", cycles < 5000, 1);
    chk("wrap_count", got.size(), 320);
    for (int j = 0; j < 320 && j < got.size(); j++) begin
      for (int b = 0; b < OW; b++) begin
        idx   = OW * j + b;
        tmp   = IW'(idx / IW);
        ex[b] = tmp[idx % IW];
      end
      chk("wrap_stream", got[j], ex);
    end
    chk("wrap_end_valid", rd_valid, 0);
    chk("wrap_end_data", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
